// File: rtl/dl_piso_pkg.sv
// rtl/dl_piso_pkg.sv - shared types for the dl_piso serializer
package dl_piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } piso_state_t;

endpackage

// File: rtl/dl_counter.sv
// rtl/dl_counter.sv - clear/enable up-counter; clear has priority over enable
module dl_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dl_piso.sv
// rtl/dl_piso.sv - parallel-in serial-out shifter with valid/ready on both sides
module dl_piso
  import dl_piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_bit,
  output logic             out_last
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt;
  logic             in_xfer;
  logic             out_xfer;

  assign out_val  = (state_q == SHIFT);
  assign out_last = out_val && (cnt == LAST_CNT);
  // Ready follows out_rdy combinationally so the next word lands on the last-bit edge.
  assign in_rdy   = (state_q == IDLE) || (out_last && out_rdy);
  assign in_xfer  = in_val && in_rdy;
  assign out_xfer = out_val && out_rdy;
  assign out_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (in_xfer) begin
      state_d = SHIFT;
      shreg_d = in_data;
    end else if (out_xfer) begin
      shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
      if (out_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Holding at WIDTH-1 after the final bit keeps cnt in range; a load clears it.
  dl_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(in_xfer),
    .en_i (out_xfer && !out_last),
    .cnt_o(cnt)
  );

endmodule

// File: tb/tb_dl_piso.sv
// tb/tb_dl_piso.sv - self-checking bench for dl_piso, LSB-first and MSB-first instances
module tb_dl_piso;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_val;
  logic out_rdy;
  logic [W-1:0] in_data;
  logic in_rdy_l, out_val_l, out_bit_l, out_last_l;
  logic in_rdy_m, out_val_m, out_bit_m, out_last_m;

  always #5 clk = ~clk;

  dl_piso #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_l), .in_data(in_data),
    .out_val(out_val_l), .out_rdy(out_rdy), .out_bit(out_bit_l), .out_last(out_last_l)
  );

  dl_piso #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_m), .in_data(in_data),
    .out_val(out_val_m), .out_rdy(out_rdy), .out_bit(out_bit_m), .out_last(out_last_m)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         eir;
    logic         eov;
    logic         ebl;
    logic         ebm;
    logic         el;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [W-1:0] d, input logic ordy,
                              input logic eir, input logic eov, input logic ebl,
                              input logic ebm, input logic el);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.ebl = ebl; v.ebm = ebm; v.el = el;
    vecs.push_back(v);
  endfunction

  task automatic check_outs(input string tag, input logic eir, input logic eov,
                            input logic ebl, input logic ebm, input logic el);
    check({tag, " in_rdy_l"},   in_rdy_l,   eir);
    check({tag, " in_rdy_m"},   in_rdy_m,   eir);
    check({tag, " out_val_l"},  out_val_l,  eov);
    check({tag, " out_val_m"},  out_val_m,  eov);
    check({tag, " out_bit_l"},  out_bit_l,  ebl);
    check({tag, " out_bit_m"},  out_bit_m,  ebm);
    check({tag, " out_last_l"}, out_last_l, el);
    check({tag, " out_last_m"}, out_last_m, el);
  endtask

  logic [W-1:0] word;
  logic [W-1:0] acc_l, acc_m, exp_w;
  logic [W-1:0] sent[$];
  logic prev_hold, pb_l, pb_m, plast;
  int pos, got, cyc;

  initial begin
    // iv  data   ordy | in_rdy out_val bit_l bit_m last
    add(1, 8'hA5, 1,  1, 0, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 1, 1, 0);
    add(0, 8'h00, 0,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(1, 8'h3C, 1,  0, 1, 1, 1, 0);
    add(1, 8'h3C, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 1, 1, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 0,  0, 1, 1, 1, 1);
    add(0, 8'h00, 1,  1, 1, 1, 1, 1);
    add(0, 8'h00, 1,  1, 0, 0, 0, 0);
    add(1, 8'h01, 0,  1, 0, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 1, 0, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(1, 8'hFF, 1,  1, 1, 0, 1, 1);
    for (int k = 0; k < 7; k++) add(1, 8'h5A, 1,  0, 1, 1, 1, 0);
    add(1, 8'h00, 1,  1, 1, 1, 1, 1);
    for (int k = 0; k < 7; k++) add(0, 8'h00, 1,  0, 1, 0, 0, 0);
    add(0, 8'h00, 1,  1, 1, 0, 0, 1);
    add(0, 8'h00, 1,  1, 0, 0, 0, 0);

    rst = 1'b1; in_val = 1'b0; out_rdy = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_val = vecs[i].iv; in_data = vecs[i].d; out_rdy = vecs[i].ordy;
      #1;
      check_outs($sformatf("row%0d", i), vecs[i].eir, vecs[i].eov, vecs[i].ebl,
                 vecs[i].ebm, vecs[i].el);
    end

    // Reset mid-word after three bits have gone out.
    @(negedge clk); in_val = 1'b1; in_data = 8'hC3; out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_val = 1'b0;
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check_outs("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    word = 8'h96;
    in_val = 1'b1; in_data = word; out_rdy = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk); in_val = 1'b0; #1;
      check_outs($sformatf("post_rst_bit%0d", k), (k == W - 1), 1'b1, word[k],
                 word[W - 1 - k], (k == W - 1));
    end
    @(negedge clk); out_rdy = 1'b0;

    // Random traffic with backpressure, checked by a word scoreboard.
    prev_hold = 1'b0; pb_l = 1'b0; pb_m = 1'b0; plast = 1'b0;
    pos = 0; got = 0; cyc = 0; acc_l = '0; acc_m = '0;
    while (got < 100 && cyc < 20000) begin
      @(negedge clk);
      in_val  = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      out_rdy = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (prev_hold) begin
        check("hold out_val", out_val_l, 1'b1);
        check("hold out_bit_l", out_bit_l, pb_l);
        check("hold out_bit_m", out_bit_m, pb_m);
        check("hold out_last", out_last_l, plast);
      end
      check("rand in_rdy", in_rdy_l, !out_val_l || (out_last_l && out_rdy));
      if (in_val && in_rdy_l) sent.push_back(in_data);
      if (out_val_l && out_rdy) begin
        acc_l[pos] = out_bit_l;
        acc_m[W - 1 - pos] = out_bit_m;
        check("rand last_l", out_last_l, (pos == W - 1));
        check("rand last_m", out_last_m, (pos == W - 1));
        if (pos == W - 1) begin
          if (sent.size() == 0) begin
            check("rand underflow", 32'd1, 32'd0);
          end else begin
            exp_w = sent.pop_front();
            check($sformatf("rand word%0d lsb", got), acc_l, exp_w);
            check($sformatf("rand word%0d msb", got), acc_m, exp_w);
          end
          got++;
          pos = 0;
        end else begin
          pos++;
        end
      end
      prev_hold = out_val_l && !out_rdy;
      pb_l = out_bit_l; pb_m = out_bit_m; plast = out_last_l;
    end
    if (got < 100) check("rand timeout", got, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
